sync_fifo_flags: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's basic buffer. Adds non-power-of-two depth, programmable almost-full/almost-empty thresholds, an occupancy output, a high-watermark, synchronous flush, pass-through push while full, and sticky overflow/underflow error flags. It sits between producer/consumer blocks in a single clock domain where rate smoothing and back-pressure monitoring are needed.

---
 rtl/sync_fifo_flags.sv | 128 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, occupancy and high-watermark outputs,
// synchronous flush, pass-through push while full, and sticky error flags.
module sync_fifo_flags #(
    parameter int DEPTH    = 6,
    parameter int DATA_W   = 8,
    parameter int AF_LEVEL = 5,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [$clog2(DEPTH+1)-1:0] max_count_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    input  logic                       err_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wPtr_q, wPtr_d;
    logic [PTR_W-1:0] rPtr_q, rPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] maxCount_q, maxCount_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic popOk;
    logic pushOk;
    logic pushReject;
    logic popReject;
    logic [CNT_W-1:0] maxBase;

    // Pointers wrap explicitly at the last entry, since DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Accept/reject decisions and next-state for pointers, occupancy and sticky flags
    always_comb begin
        popOk       = pop_i && (count_q != '0);
        pushOk      = push_i && ((count_q != FULL_CNT) || popOk);
        pushReject  = !flush_i && push_i && !pushOk;
        popReject   = !flush_i && pop_i && !popOk;

        wPtr_d  = wPtr_q;
        rPtr_d  = rPtr_q;
        count_d = count_q;

        if (flush_i) begin
            wPtr_d  = '0;
            rPtr_d  = '0;
            count_d = '0;
        end else begin
            if (pushOk) begin
                wPtr_d = nextPtr(wPtr_q);
            end
            if (popOk) begin
                rPtr_d = nextPtr(rPtr_q);
            end
            if (pushOk && !popOk) begin
                count_d = count_q + CNT_W'(1);
            end else if (popOk && !pushOk) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        overflow_d  = (err_clr_i ? 1'b0 : overflow_q) | pushReject;
        underflow_d = (err_clr_i ? 1'b0 : underflow_q) | popReject;

        maxBase    = err_clr_i ? '0 : maxCount_q;
        maxCount_d = (count_d > maxBase) ? count_d : maxBase;
    end

    // Control state register with immediate asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wPtr_q      <= '0;
            rPtr_q      <= '0;
            count_q     <= '0;
            maxCount_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wPtr_q      <= wPtr_d;
            rPtr_q      <= rPtr_d;
            count_q     <= count_d;
            maxCount_q  <= maxCount_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is never reset; a flush only moves the pointers
    always_ff @(posedge clk) begin
        if (pushOk && !flush_i) begin
            mem[wPtr_q] <= push_data_i;
        end
    end

    assign pop_data_o     = mem[rPtr_q];
    assign full_o         = (count_q == FULL_CNT);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AF_CNT);
    assign almost_empty_o = (count_q <= AE_CNT);
    assign count_o        = count_q;
    assign max_count_o    = maxCount_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based behavioural model of the FIFO.
module tb_sync_fifo_flags;

    localparam int DEPTH    = 6;
    localparam int DATA_W   = 8;
    localparam int AF_LEVEL = 5;
    localparam int AE_LEVEL = 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush_i = 1'b0;
    logic              push_i = 1'b0;
    logic [DATA_W-1:0] push_data_i = '0;
    logic              pop_i = 1'b0;
    logic              err_clr_i = 1'b0;
    logic [DATA_W-1:0] pop_data_o;
    logic              full_o, empty_o, almost_full_o, almost_empty_o;
    logic [CNT_W-1:0]  count_o, max_count_o;
    logic              overflow_o, underflow_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model: contents as a queue, plus watermark and sticky flags
    logic [DATA_W-1:0] mdlQ [$];
    int                mdlMax = 0;
    bit                mdlOvf = 1'b0;
    bit                mdlUnf = 1'b0;

    sync_fifo_flags #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .push_i(push_i),
        .push_data_i(push_data_i), .pop_i(pop_i), .pop_data_o(pop_data_o),
        .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o), .count_o(count_o), .max_count_o(max_count_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearModel();
        mdlQ.delete();
        mdlMax = 0;
        mdlOvf = 1'b0;
        mdlUnf = 1'b0;
    endtask

    // Advance the model by one clock using the rules of the FIFO, not its structure
    task automatic modelEdge();
        bit popOk, pushOk, ovfSet, unfSet;
        int base;
        ovfSet = 1'b0;
        unfSet = 1'b0;
        if (flush_i) begin
            mdlQ.delete();
        end else begin
            popOk  = pop_i && (mdlQ.size() > 0);
            pushOk = push_i && ((mdlQ.size() < DEPTH) || popOk);
            if (popOk) void'(mdlQ.pop_front());
            if (pushOk) mdlQ.push_back(push_data_i);
            ovfSet = push_i && !pushOk;
            unfSet = pop_i && !popOk;
        end
        mdlOvf = (err_clr_i ? 1'b0 : mdlOvf) | ovfSet;
        mdlUnf = (err_clr_i ? 1'b0 : mdlUnf) | unfSet;
        base   = err_clr_i ? 0 : mdlMax;
        mdlMax = (mdlQ.size() > base) ? mdlQ.size() : base;
    endtask

    task automatic checkOutput();
        int n;
        n = mdlQ.size();
        checkVal("count", 32'(count_o), 32'(n));
        checkVal("empty", 32'(empty_o), 32'(n == 0));
        checkVal("full", 32'(full_o), 32'(n == DEPTH));
        checkVal("almost_full", 32'(almost_full_o), 32'(n >= AF_LEVEL));
        checkVal("almost_empty", 32'(almost_empty_o), 32'(n <= AE_LEVEL));
        checkVal("max_count", 32'(max_count_o), 32'(mdlMax));
        checkVal("overflow", 32'(overflow_o), 32'(mdlOvf));
        checkVal("underflow", 32'(underflow_o), 32'(mdlUnf));
        if (n > 0) checkVal("pop_data", 32'(pop_data_o), 32'(mdlQ[0]));
    endtask

    // Single compare process: update the model at each edge, then check shortly after
    always @(posedge clk) begin
        if (reset) clearModel();
        else modelEdge();
        #2;
        checkOutput();
    end

    // Drive one cycle of inputs at the falling edge and return at the next falling edge
    task automatic applyStimulus(input bit fl, input bit pu, input logic [DATA_W-1:0] d,
                                 input bit po, input bit clr);
        flush_i     = fl;
        push_i      = pu;
        push_data_i = d;
        pop_i       = po;
        err_clr_i   = clr;
        @(negedge clk);
        flush_i   = 1'b0;
        push_i    = 1'b0;
        pop_i     = 1'b0;
        err_clr_i = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearModel();
        #1;
        checkVal("rst_count", 32'(count_o), 32'd0);
        checkVal("rst_max", 32'(max_count_o), 32'd0);
        checkVal("rst_empty", 32'(empty_o), 32'd1);
        checkVal("rst_full", 32'(full_o), 32'd0);
        checkVal("rst_ae", 32'(almost_empty_o), 32'd1);
        checkVal("rst_af", 32'(almost_full_o), 32'd0);
        checkVal("rst_ovf", 32'(overflow_o), 32'd0);
        checkVal("rst_unf", 32'(underflow_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] wrapNext;
        @(negedge clk);
        doReset();

        // Fill and drain in order, watching the thresholds
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 1, 8'(i), 0, 0);
            checkVal("fill_count", 32'(count_o), 32'(i));
            checkVal("fill_full", 32'(full_o), 32'(i == 6));
            checkVal("fill_af", 32'(almost_full_o), 32'(i >= 5));
        end
        for (int i = 1; i <= 6; i++) begin
            checkVal("drain_data", 32'(pop_data_o), 32'(i));
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkVal("drain_empty", 32'(empty_o), 32'd1);

        // Overflow, then pass-through push while full
        for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 8'(i), 0, 0);
        applyStimulus(0, 1, 8'hAA, 0, 0);
        checkVal("ovf_flag", 32'(overflow_o), 32'd1);
        checkVal("ovf_count", 32'(count_o), 32'd6);
        checkVal("pt_head", 32'(pop_data_o), 32'h01);
        applyStimulus(0, 1, 8'hBB, 1, 0);
        checkVal("pt_count", 32'(count_o), 32'd6);
        checkVal("pt_next", 32'(pop_data_o), 32'h02);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0);
        checkVal("pt_tail", 32'(pop_data_o), 32'hBB);
        applyStimulus(0, 0, 0, 1, 0);

        // Underflow, then push and pop together while empty
        doReset();
        applyStimulus(0, 0, 0, 1, 0);
        checkVal("unf_flag", 32'(underflow_o), 32'd1);
        checkVal("unf_count", 32'(count_o), 32'd0);
        applyStimulus(0, 1, 8'h10, 1, 0);
        checkVal("pp_empty_count", 32'(count_o), 32'd1);
        checkVal("pp_empty_head", 32'(pop_data_o), 32'h10);
        applyStimulus(0, 0, 0, 1, 0);

        // Wrap-around at constant occupancy of three
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'(8'h20 + i), 0, 0);
        wrapNext = 8'h20;
        for (int i = 0; i < 20; i++) begin
            checkVal("wrap_head", 32'(pop_data_o), 32'(wrapNext));
            applyStimulus(0, 1, 8'(8'h23 + i), 1, 0);
            wrapNext = wrapNext + 8'd1;
        end
        checkVal("wrap_max", 32'(max_count_o), 32'd3);
        checkVal("wrap_count", 32'(count_o), 32'd3);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);

        // Flush beats a simultaneous push; watermark survives until cleared
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'h40 + i), 0, 0);
        applyStimulus(1, 1, 8'hEE, 0, 0);
        checkVal("flush_count", 32'(count_o), 32'd0);
        checkVal("flush_empty", 32'(empty_o), 32'd1);
        checkVal("flush_ovf", 32'(overflow_o), 32'd0);
        checkVal("flush_max", 32'(max_count_o), 32'd4);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("clr_max", 32'(max_count_o), 32'd0);

        // Reset mid-stream, then the next push becomes the head
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'(8'h60 + i), 0, 0);
        doReset();
        applyStimulus(0, 1, 8'h55, 0, 0);
        checkVal("post_rst_head", 32'(pop_data_o), 32'h55);
        checkVal("post_rst_count", 32'(count_o), 32'd1);

        // Randomized traffic with occasional flush and error clear
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
                          8'($urandom), ($urandom_range(0, 9) < 5),
                          ($urandom_range(0, 29) == 0));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
